// File: rtl/dmem_access_unit_if.sv
// Request/response handshake bundle between the MEM stage and dmem_access_unit.
// The master side issues load/store requests; the slave side is the access unit.
interface dmem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_base;
  logic [8:0]  req_offset;
  logic [63:0] req_wdata0;
  logic [63:0] req_wdata1;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata0;
  logic [63:0] rsp_rdata1;
  logic        rsp_fault;

  modport master (
    output req_valid, req_op, req_base, req_offset, req_wdata0, req_wdata1,
    input  req_ready,
    input  rsp_valid, rsp_rdata0, rsp_rdata1, rsp_fault,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_base, req_offset, req_wdata0, req_wdata1,
    output req_ready,
    output rsp_valid, rsp_rdata0, rsp_rdata1, rsp_fault,
    input  rsp_ready
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store initiator for the LEGv8 data memory: checks alignment and range at
// acceptance, then performs one (LDUR/STUR) or two (LDP/STP) word accesses.
module dmem_access_unit #(
  parameter int MEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_unit_if.slave bus,
  output logic              mem_read,
  output logic              mem_write,
  output logic [63:0]       mem_addr_out,
  output logic [63:0]       mem_write_data,
  input  logic [63:0]       mem_data_in
);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  typedef enum logic [1:0] {OP_LDUR = 2'b00, OP_STUR = 2'b01, OP_LDP = 2'b10, OP_STP = 2'b11} op_t;

  state_t        state;
  op_t           op;
  logic [IW-1:0] idx;
  logic [63:0]   wdata1;

  logic [63:0] ea;
  logic [60:0] word;
  logic        req_store;
  logic        req_pair;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic        op_store;
  logic        op_pair;

  // Pair ops need both words in range, so the whole op faults before any write.
  always_comb begin
    ea           = bus.req_base + {{55{bus.req_offset[8]}}, bus.req_offset};
    word         = ea[63:3];
    req_store    = bus.req_op[0];
    req_pair     = bus.req_op[1];
    misaligned   = (ea[2:0] != 3'b000);
    out_of_range = req_pair ? (word >= 61'(MEM_DEPTH - 1)) : (word >= 61'(MEM_DEPTH));
    fault        = misaligned || out_of_range;
    op_store     = (op == OP_STUR) || (op == OP_STP);
    op_pair      = (op == OP_LDP) || (op == OP_STP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op             <= OP_LDUR;
      idx            <= '0;
      wdata1         <= '0;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_fault  <= 1'b0;
      bus.rsp_rdata0 <= '0;
      bus.rsp_rdata1 <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr_out   <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op             <= op_t'(bus.req_op);
            idx            <= word[IW-1:0];
            wdata1         <= bus.req_wdata1;
            bus.req_ready  <= 1'b0;
            bus.rsp_fault  <= fault;
            bus.rsp_rdata0 <= '0;
            bus.rsp_rdata1 <= '0;
            if (fault) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
            end else begin
              state          <= ACC0;
              mem_read       <= !req_store;
              mem_write      <= req_store;
              mem_addr_out   <= 64'(word[IW-1:0]);
              mem_write_data <= req_store ? bus.req_wdata0 : 64'd0;
            end
          end
        end

        ACC0: begin
          if (!op_store) begin
            bus.rsp_rdata0 <= mem_data_in;
          end
          if (op_pair) begin
            state          <= ACC1;
            mem_addr_out   <= 64'(idx) + 64'd1;
            mem_write_data <= op_store ? wdata1 : 64'd0;
          end else begin
            state          <= RESP;
            bus.rsp_valid  <= 1'b1;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr_out   <= '0;
            mem_write_data <= '0;
          end
        end

        ACC1: begin
          if (!op_store) begin
            bus.rsp_rdata1 <= mem_data_in;
          end
          state          <= RESP;
          bus.rsp_valid  <= 1'b1;
          mem_read       <= 1'b0;
          mem_write      <= 1'b0;
          mem_addr_out   <= '0;
          mem_write_data <= '0;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table, hand-written
// backpressure/reset sequences, then random requests against a word-array model.
module tb_dmem_access_unit;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_access_unit_if bus();

  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr_out;
  logic [63:0] mem_write_data;
  logic [63:0] mem_data_in;

  dmem_access_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr_out  (mem_addr_out),
    .mem_write_data(mem_write_data),
    .mem_data_in   (mem_data_in)
  );

  logic [63:0] mem     [DEPTH];
  logic [63:0] ref_mem [DEPTH];

  assign mem_data_in = (mem_addr_out < 64'(DEPTH)) ? mem[mem_addr_out[3:0]] : 64'd0;

  always @(posedge clk) begin
    if (mem_write && mem_addr_out < 64'(DEPTH)) mem[mem_addr_out[3:0]] <= mem_write_data;
  end

  int tests_run = 0;
  int tests_failed = 0;

  logic        exp_fault;
  logic [63:0] exp_rd0, exp_rd1, exp_addr;
  int          exp_lat, exp_reads, exp_writes;

  logic        got_fault, mem_busy_resp, timed_out;
  logic [63:0] got_rd0, got_rd1;
  logic [63:0] addr_seen [2];
  int          got_lat, got_reads, got_writes;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] base;
    logic [8:0]  off;
    logic [63:0] wd0;
    logic [63:0] wd1;
    logic        fault;
    logic [63:0] rd0;
    logic [63:0] rd1;
    int          lat;
    logic [63:0] addr;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctl"}, 64'({bus.req_ready, bus.rsp_valid, bus.rsp_fault, mem_read, mem_write}), 64'b10000);
    checkOutput({tag, "_rdata0"}, bus.rsp_rdata0, 64'd0);
    checkOutput({tag, "_rdata1"}, bus.rsp_rdata1, 64'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr_out, 64'd0);
    checkOutput({tag, "_mem_wdata"}, mem_write_data, 64'd0);
  endtask

  // Reference: byte EA -> word array; a fault means no access at all.
  task automatic modelTxn(input logic [1:0] op, input logic [63:0] base, input logic [8:0] off,
                          input logic [63:0] wd0, input logic [63:0] wd1);
    logic signed [63:0] soff;
    logic [63:0] ea, w;
    int n;
    bit store;
    soff  = $signed(off);
    ea    = base + soff;
    w     = ea / 8;
    n     = (op == 2'b10 || op == 2'b11) ? 2 : 1;
    store = (op == 2'b01 || op == 2'b11);
    exp_fault  = (ea % 8 != 0) || (w + 64'(n) > 64'(DEPTH));
    exp_rd0    = 64'd0;
    exp_rd1    = 64'd0;
    exp_reads  = 0;
    exp_writes = 0;
    exp_addr   = w;
    if (exp_fault) begin
      exp_lat = 1;
    end else begin
      exp_lat = n + 1;
      if (store) begin
        ref_mem[int'(w)] = wd0;
        if (n == 2) ref_mem[int'(w) + 1] = wd1;
        exp_writes = n;
      end else begin
        exp_rd0 = ref_mem[int'(w)];
        if (n == 2) exp_rd1 = ref_mem[int'(w) + 1];
        exp_reads = n;
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] base, input logic [8:0] off,
                               input logic [63:0] wd0, input logic [63:0] wd1, input int ready_delay);
    int cyc, acc;
    got_lat = 0; got_reads = 0; got_writes = 0; timed_out = 1'b0; mem_busy_resp = 1'b0;
    got_fault = 1'b0; got_rd0 = 64'd0; got_rd1 = 64'd0;
    addr_seen[0] = 64'd0; addr_seen[1] = 64'd0;
    @(negedge clk);
    checkOutput("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_wdata0 = wd0;
    bus.req_wdata1 = wd1;
    bus.rsp_ready  = (ready_delay == 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    cyc = 0;
    acc = 0;
    while (got_lat == 0 && !timed_out) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) begin
        got_lat       = cyc;
        got_fault     = bus.rsp_fault;
        got_rd0       = bus.rsp_rdata0;
        got_rd1       = bus.rsp_rdata1;
        mem_busy_resp = mem_read || mem_write || (mem_addr_out != 0) || (mem_write_data != 0);
        checkOutput("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
      end else begin
        if (mem_read || mem_write) begin
          if (acc < 2) addr_seen[acc] = mem_addr_out;
          acc++;
          if (mem_read) got_reads++;
          if (mem_write) got_writes++;
        end
        if (cyc >= 20) timed_out = 1'b1;
      end
    end
    if (timed_out) begin
      checkOutput("rsp_timeout", 64'd1, 64'd0);
      bus.rsp_ready = 1'b1;
    end else begin
      for (int k = 0; k < ready_delay; k++) begin
        @(negedge clk);
        checkOutput("hold_ctl", 64'({bus.rsp_valid, bus.req_ready, bus.rsp_fault}), 64'({2'b10, exp_fault}));
        checkOutput("hold_rdata0", bus.rsp_rdata0, exp_rd0);
        checkOutput("hold_rdata1", bus.rsp_rdata1, exp_rd1);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("idle_after_rsp", 64'({bus.req_ready, bus.rsp_valid}), 64'b10);
    end
  endtask

  task automatic checkTxn(input string tag);
    int bad;
    checkOutput({tag, "_fault"}, 64'(got_fault), 64'(exp_fault));
    checkOutput({tag, "_rdata0"}, got_rd0, exp_rd0);
    checkOutput({tag, "_rdata1"}, got_rd1, exp_rd1);
    checkOutput({tag, "_latency"}, 64'(got_lat), 64'(exp_lat));
    checkOutput({tag, "_reads"}, 64'(got_reads), 64'(exp_reads));
    checkOutput({tag, "_writes"}, 64'(got_writes), 64'(exp_writes));
    if (exp_reads + exp_writes > 0) checkOutput({tag, "_addr0"}, addr_seen[0], exp_addr);
    if (exp_reads + exp_writes == 2) checkOutput({tag, "_addr1"}, addr_seen[1], exp_addr + 64'd1);
    checkOutput({tag, "_mem_idle_in_resp"}, 64'(mem_busy_resp), 64'd0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    checkOutput({tag, "_mem_image"}, 64'(bad), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_base   = 64'd0;
    bus.req_offset = 9'd0;
    bus.req_wdata0 = 64'd0;
    bus.req_wdata1 = 64'd0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 64'd0;
      ref_mem[i] = 64'd0;
    end
    mem[0] = 64'h15; mem[1] = 64'hC4; mem[5] = 64'hFF; mem[6] = 64'hAA; mem[7] = 64'hAA;
    ref_mem[0] = 64'h15; ref_mem[1] = 64'hC4; ref_mem[5] = 64'hFF; ref_mem[6] = 64'hAA; ref_mem[7] = 64'hAA;

    //                op     base                    off     wd0         wd1      flt  rd0          rd1       lat addr
    vecs[0]  = '{2'b00, 64'h28,                 9'h000, 64'h0,      64'h0,  1'b0, 64'hFF,     64'h0,    2, 64'd5};
    vecs[1]  = '{2'b01, 64'h30,                 9'h008, 64'h1234,   64'h0,  1'b0, 64'h0,      64'h0,    2, 64'd7};
    vecs[2]  = '{2'b00, 64'h38,                 9'h000, 64'h0,      64'h0,  1'b0, 64'h1234,   64'h0,    2, 64'd7};
    vecs[3]  = '{2'b10, 64'h0,                  9'h000, 64'h0,      64'h0,  1'b0, 64'h15,     64'hC4,   3, 64'd0};
    vecs[4]  = '{2'b01, 64'h2C,                 9'h000, 64'hDEAD,   64'h0,  1'b1, 64'h0,      64'h0,    1, 64'd5};
    vecs[5]  = '{2'b11, 64'h78,                 9'h000, 64'h1,      64'h2,  1'b1, 64'h0,      64'h0,    1, 64'd15};
    vecs[6]  = '{2'b00, 64'h78,                 9'h000, 64'h0,      64'h0,  1'b0, 64'h0,      64'h0,    2, 64'd15};
    vecs[7]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFF8, 9'h008, 64'h0,     64'h0,  1'b0, 64'h15,     64'h0,    2, 64'd0};
    vecs[8]  = '{2'b00, 64'h10,                 9'h1F8, 64'h0,      64'h0,  1'b0, 64'hC4,     64'h0,    2, 64'd1};
    vecs[9]  = '{2'b00, 64'h80,                 9'h000, 64'h0,      64'h0,  1'b1, 64'h0,      64'h0,    1, 64'd16};
    vecs[10] = '{2'b11, 64'h70,                 9'h000, 64'h77,     64'h88, 1'b0, 64'h0,      64'h0,    3, 64'd14};
    vecs[11] = '{2'b10, 64'h70,                 9'h000, 64'h0,      64'h0,  1'b0, 64'h77,     64'h88,   3, 64'd14};
    vecs[12] = '{2'b00, 64'h0,                  9'h1F8, 64'h0,      64'h0,  1'b1, 64'h0,      64'h0,    1, 64'd0};
    vecs[13] = '{2'b10, 64'h70,                 9'h008, 64'h0,      64'h0,  1'b1, 64'h0,      64'h0,    1, 64'd15};
    vecs[14] = '{2'b00, 64'h2D,                 9'h000, 64'h0,      64'h0,  1'b1, 64'h0,      64'h0,    1, 64'd5};

    repeat (2) @(negedge clk);
    checkResetState("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    checkResetState("after_reset");

    for (int v = 0; v < NVEC; v++) begin
      modelTxn(vecs[v].op, vecs[v].base, vecs[v].off, vecs[v].wd0, vecs[v].wd1);
      exp_fault = vecs[v].fault;
      exp_rd0   = vecs[v].rd0;
      exp_rd1   = vecs[v].rd1;
      exp_lat   = vecs[v].lat;
      exp_addr  = vecs[v].addr;
      applyStimulus(vecs[v].op, vecs[v].base, vecs[v].off, vecs[v].wd0, vecs[v].wd1, 0);
      checkTxn($sformatf("vec%0d", v));
    end

    // Response held off for five cycles must stay frozen.
    modelTxn(2'b00, 64'h28, 9'h000, 64'h0, 64'h0);
    applyStimulus(2'b00, 64'h28, 9'h000, 64'h0, 64'h0, 5);
    checkTxn("backpressure");

    // Reset during the second beat of an STP: first word lands, second must not.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'b11;
    bus.req_base   = 64'h28;
    bus.req_offset = 9'h000;
    bus.req_wdata0 = 64'h11;
    bus.req_wdata1 = 64'h22;
    bus.rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("stp_acc0", 64'({mem_write, mem_addr_out[3:0]}), 64'({1'b1, 4'd5}));
    checkOutput("stp_acc0_wdata", mem_write_data, 64'h11);
    @(negedge clk);
    checkOutput("stp_acc1", 64'({mem_write, mem_addr_out[3:0]}), 64'({1'b1, 4'd6}));
    rst = 1'b1;
    #1;
    checkResetState("reset_in_acc1");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_stp_word5", mem[5], 64'h11);
    checkOutput("reset_stp_word6", mem[6], 64'hAA);
    checkResetState("after_mid_reset");
    ref_mem[5] = 64'h11;

    for (int n = 0; n < 300; n++) begin
      logic [1:0]         op;
      logic [63:0]        ea, base, wd0, wd1;
      logic [8:0]         off;
      logic signed [63:0] soff;
      int                 kind;
      op   = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      if (kind == 0)      ea = {$urandom, $urandom};
      else if (kind == 1) ea = 64'($urandom_range(0, 17)) * 64'd8 + 64'($urandom_range(1, 7));
      else                ea = 64'($urandom_range(0, 16)) * 64'd8;
      off  = 9'($urandom_range(0, 511));
      soff = $signed(off);
      base = ea - soff;
      wd0  = {$urandom, $urandom};
      wd1  = {$urandom, $urandom};
      modelTxn(op, base, off, wd0, wd1);
      applyStimulus(op, base, off, wd0, wd1, $urandom_range(0, 2));
      checkTxn($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
